spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter: DATA_W, default 8, transfer length in bits.
REQ-002 Parameter: DIV_LOG2, default 4, SCLK half-period H = 2^DIV_LOG2 clk cycles (default SCLK = clk/32).
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  transfer request; sampled only in IDLE.
REQ-006 tx_data  input  DATA_W  byte to send; captured in the cycle start is accepted.
REQ-007 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-008 done  output  1  one-cycle pulse when rx_data is valid.
REQ-009 rx_data  output  DATA_W  last received word; holds until the next done.
REQ-010 spi_sclk  output  1  serial clock; mode 0 (CPOL=0, CPHA=0).
REQ-011 spi_mosi  output  1  serial data out, MSB first.
REQ-012 spi_miso  input  1  serial data in, MSB first.
REQ-013 spi_cs_n  output  1  active-low chip select.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, TRANSFER, HOLD, DONE; all outputs registered.
REQ-015 IDLE: cs_n=1, sclk=0, busy=0, done=0; start=1 at cycle t0 -> load shift register with tx_data, clear divider, go SETUP.
REQ-016 SETUP: cs_n=0, mosi=tx_data[DATA_W-1]; after one half-period tick (cycle t0+H) -> TRANSFER.
REQ-017 Divider tick SHALL assert when the half-period counter equals H-1; counter wraps to 0 on tick and is cleared on leaving IDLE.
REQ-018 TRANSFER: each tick toggles sclk; on a 0->1 toggle, spi_miso is shifted into the receive register LSB; on a 1->0 toggle, mosi advances to the next bit.
REQ-019 After 2*DATA_W ticks in TRANSFER (last at t0+H+2*DATA_W*H), sclk SHALL be 0 and FSM -> HOLD.
REQ-020 HOLD: cs_n stays 0 for one half-period, then -> DONE.
REQ-021 DONE (cycle t0+(2*DATA_W+2)*H+1; 289 for defaults): cs_n=1, done=1, rx_data updated, busy=1; next cycle -> IDLE.
REQ-022 start while not IDLE SHALL be ignored; no queueing.
REQ-023 start held continuously SHALL begin a new transfer in the first IDLE cycle; cs_n SHALL be high for at least 2 clk cycles between transfers.
REQ-024 spi_mosi SHALL be 0 in IDLE.

Reset
REQ-025 On reset=1 at any clk edge, including mid-transfer, the next state SHALL be IDLE with cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, divider=0.
REQ-026 An aborted transfer SHALL NOT assert done nor change rx_data other than clearing it.

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum and default values of DATA_W and DIV_LOG2.
REQ-028 Half-period tick generation SHALL be a sub-module spi_clk_div (inputs clk, reset, clear; output tick; parameter DIV_LOG2).

Verification
REQ-029 Loopback miso=mosi, tx_data=0xA5, start at t0 -> rx_data=0xA5, done exactly at t0+289, one cycle wide.
REQ-030 Slave model returns 0x3C, tx_data=0xFF -> mosi shows 8 ones, rx_data=0x3C; exactly 8 sclk rising edges, 32-clk period.
REQ-031 start pulsed again at t0+50 during busy -> ignored; exactly one done.
REQ-032 reset asserted at t0+100 for 1 cycle -> next cycle cs_n=1, sclk=0, busy=0; no done follows.
REQ-033 start held high for two transfers (0x12, 0x34 loopback) -> two done pulses 290 cycles apart, cs_n high ≥2 cycles between.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master controller.
//   state_t            FSM state encoding (IDLE, SETUP, TRANSFER, HOLD, DONE)
//   DATA_W_DEFAULT     default transfer length in bits
//   DIV_LOG2_DEFAULT   default log2 of the SCLK half-period in clk cycles
package spi_pkg;

   localparam int DATA_W_DEFAULT   = 8;
   localparam int DIV_LOG2_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      TRANSFER,
      HOLD,
      DONE
   } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator for the SPI master.
//   clk    in   system clock (rising edge)
//   reset  in   synchronous active-high reset
//   clear  in   holds the counter at zero while asserted
//   tick   out  high for one cycle when the counter equals 2^DIV_LOG2 - 1
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int DIV_LOG2 = DIV_LOG2_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   logic [DIV_LOG2-1:0] count;

   // Counter width equals log2 of the half-period, so the natural
   // roll-over after the all-ones value is the wrap to zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = &count;

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-word SPI master, mode 0, MSB first.
//   clk, reset       system clock, synchronous active-high reset
//   start, tx_data   transfer request (IDLE only) and word to send
//   busy, done       transfer in progress / one-cycle completion pulse
//   rx_data          last received word, held until the next done
//   spi_sclk, spi_mosi, spi_miso, spi_cs_n   SPI bus
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int DIV_LOG2 = DIV_LOG2_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              spi_sclk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n
);

   localparam int EDGES = 2 * DATA_W;
   localparam int EW    = $clog2(EDGES) + 1;

   state_t            state;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic [DATA_W-1:0] tx_next;
   logic [DATA_W-1:0] rx_next;
   logic [EW-1:0]     edge_cnt;
   logic              tick;
   logic              div_clear;

   // Divider is held at zero throughout IDLE, so it starts from zero in
   // the first SETUP cycle.
   assign div_clear = (state == IDLE);

   spi_clk_div #(
      .DIV_LOG2(DIV_LOG2)
   ) u_clk_div (
      .clk   (clk),
      .reset (reset),
      .clear (div_clear),
      .tick  (tick)
   );

   always_comb begin
      tx_next = tx_sr << 1;
      rx_next = (rx_sr << 1) | DATA_W'(spi_miso);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         edge_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         spi_cs_n <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               spi_cs_n <= 1'b1;
               spi_sclk <= 1'b0;
               spi_mosi <= 1'b0;
               busy     <= 1'b0;
               if (start) begin
                  tx_sr    <= tx_data;
                  edge_cnt <= '0;
                  spi_cs_n <= 1'b0;
                  spi_mosi <= tx_data[DATA_W-1];
                  busy     <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (tick) begin
                  state <= TRANSFER;
               end
            end
            TRANSFER: begin
               if (tick) begin
                  spi_sclk <= ~spi_sclk;
                  if (!spi_sclk) begin
                     // rising edge: capture slave data
                     rx_sr <= rx_next;
                  end else begin
                     // falling edge: present the next bit
                     tx_sr    <= tx_next;
                     spi_mosi <= tx_next[DATA_W-1];
                  end
                  edge_cnt <= edge_cnt + 1'b1;
                  if (edge_cnt == EW'(EDGES - 1)) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  spi_cs_n <= 1'b1;
                  done     <= 1'b1;
                  rx_data  <= rx_sr;
                  state    <= DONE;
               end
            end
            DONE: begin
               busy     <= 1'b0;
               spi_mosi <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;

   localparam int DW       = 8;
   localparam int DL       = 4;
   localparam int H        = 1 << DL;
   localparam int XFER_END = H + 2 * DW * H;
   localparam int DONE_REL = (2 * DW + 2) * H + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          busy, done, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
   logic [DW-1:0] rx_data;

   logic          loopback = 1'b1;
   logic [DW-1:0] slave_word = '0;
   int            scnt = 0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model state
   bit            m_valid = 0;
   bit            m_active = 0;
   int            m_t0 = 0;
   logic [DW-1:0] m_tx = '0;
   logic [DW-1:0] m_word = '0;
   logic [DW-1:0] m_rx = '0;

   // observations
   int            done_q[$];
   logic [DW-1:0] rx_done_q[$];
   int            rise_q[$];
   int            cs_gap_q[$];
   int            mosi_ones = 0;
   int            cs_run = 0;
   logic          prev_sclk = 1'b0;
   logic          prev_cs = 1'b1;

   spi_master_ctrl #(
      .DATA_W   (DW),
      .DIV_LOG2 (DL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_cs_n (spi_cs_n)
   );

   always #5 clk = ~clk;

   // Slave: first bit valid when CS falls, next bit after each SCLK fall.
   always @(negedge spi_sclk or posedge spi_cs_n) begin
      if (spi_cs_n === 1'b1) scnt <= 0;
      else                   scnt <= scnt + 1;
   end

   always_comb begin
      spi_miso = 1'b0;
      if (loopback) spi_miso = spi_mosi;
      else if (scnt < DW) spi_miso = slave_word[3'(DW - 1 - scnt)];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare outputs, record events, then advance the model by one edge.
   always @(negedge clk) begin : compare
      logic e_cs, e_sclk, e_mosi, e_busy, e_done, mosi_chk;
      int   rel, p;
      if (m_valid) begin
         e_cs = 1; e_sclk = 0; e_mosi = 0; e_busy = 0; e_done = 0; mosi_chk = 1;
         if (m_active) begin
            rel = cyc - m_t0;
            e_busy = 1;
            if (rel <= H) begin
               e_cs = 0; e_mosi = m_tx[DW-1];
            end else if (rel <= XFER_END) begin
               p = (rel - H - 1) / H;
               e_cs = 0; e_sclk = p[0]; e_mosi = m_tx[DW - 1 - p / 2];
            end else if (rel < DONE_REL) begin
               e_cs = 0; mosi_chk = 0;
            end else begin
               e_done = 1; mosi_chk = 0;
            end
         end
         check("cs_n", spi_cs_n, e_cs);
         check("sclk", spi_sclk, e_sclk);
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("rx_data", rx_data, m_rx);
         if (mosi_chk) check("mosi", spi_mosi, e_mosi);

         if (done === 1'b1) begin
            done_q.push_back(cyc);
            rx_done_q.push_back(rx_data);
         end
         if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_q.push_back(cyc);
            if (spi_mosi === 1'b1) mosi_ones++;
         end
         if (spi_cs_n === 1'b1) cs_run++;
         else begin
            if (prev_cs === 1'b1 && cs_run > 0) cs_gap_q.push_back(cs_run);
            cs_run = 0;
         end
         prev_sclk = spi_sclk;
         prev_cs   = spi_cs_n;
      end

      if (reset) begin
         m_valid = 1; m_active = 0; m_rx = '0;
      end else if (m_valid) begin
         if (m_active) begin
            rel = cyc - m_t0;
            if (rel == DONE_REL - 1) m_rx = m_word;
            if (rel == DONE_REL) m_active = 0;
         end else if (start) begin
            m_active = 1; m_t0 = cyc; m_tx = tx_data;
            m_word = loopback ? tx_data : slave_word;
         end
      end
      cyc++;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) next_cycle();
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 2000) begin
         next_cycle();
         k++;
      end
      check("wait_idle", busy, 1'b0);
   endtask

   task automatic clear_obs();
      done_q.delete(); rx_done_q.delete(); rise_q.delete(); cs_gap_q.delete();
      mosi_ones = 0;
   endtask

   task automatic launch(input logic [DW-1:0] tx, input logic lb, input logic [DW-1:0] sw,
                         output int t0);
      loopback = lb; slave_word = sw; tx_data = tx; start = 1'b1; t0 = cyc;
      next_cycle();
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      cycles(3);
      reset = 1'b0;
      next_cycle();
      check("reset_cs_n", spi_cs_n, 1'b1);
      check("reset_rx", rx_data, 8'h00);

      // loopback 0xA5
      clear_obs();
      launch(8'hA5, 1'b1, 8'h00, t0);
      cycles(300);
      check("a5_done_count", done_q.size(), 1);
      if (done_q.size() > 0) check("a5_done_cycle", done_q[0] - t0, 289);
      check("a5_rx", rx_data, 8'hA5);
      check("a5_rises", rise_q.size(), 8);
      if (rise_q.size() > 1) check("a5_period", rise_q[1] - rise_q[0], 32);

      // slave returns 0x3C, tx 0xFF
      wait_idle(); clear_obs();
      launch(8'hFF, 1'b0, 8'h3C, t0);
      cycles(300);
      check("3c_rx", rx_data, 8'h3C);
      check("3c_done_count", done_q.size(), 1);
      check("3c_rises", rise_q.size(), 8);
      check("3c_mosi_ones", mosi_ones, 8);
      if (rise_q.size() > 7) check("3c_period", rise_q[7] - rise_q[6], 32);

      // start while busy is ignored
      wait_idle(); clear_obs();
      launch(8'h5A, 1'b1, 8'h00, t0);
      cycles(49);
      start = 1'b1; tx_data = 8'hC3;
      next_cycle();
      start = 1'b0;
      cycles(260);
      check("ign_done_count", done_q.size(), 1);
      if (done_q.size() > 0) check("ign_done_cycle", done_q[0] - t0, 289);
      check("ign_rx", rx_data, 8'h5A);

      // reset mid-transfer
      wait_idle(); clear_obs();
      launch(8'h96, 1'b1, 8'h00, t0);
      cycles(99);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("abort_cs_n", spi_cs_n, 1'b1);
      check("abort_sclk", spi_sclk, 1'b0);
      check("abort_busy", busy, 1'b0);
      cycles(400);
      check("abort_no_done", done_q.size(), 0);
      check("abort_rx", rx_data, 8'h00);

      // start held for two back-to-back transfers
      wait_idle(); clear_obs();
      loopback = 1'b1; tx_data = 8'h12; start = 1'b1; t0 = cyc;
      next_cycle();
      tx_data = 8'h34;
      cycles(579);
      start = 1'b0;
      cycles(10);
      check("held_done_count", done_q.size(), 2);
      if (done_q.size() > 1) begin
         check("held_first_done", done_q[0] - t0, 289);
         check("held_spacing", done_q[1] - done_q[0], 290);
         check("held_rx0", rx_done_q[0], 8'h12);
         check("held_rx1", rx_done_q[1], 8'h34);
      end
      if (cs_gap_q.size() > 0) check("held_cs_gap_ge2", cs_gap_q[$] >= 2, 1'b1);
      else check("held_cs_gap_seen", cs_gap_q.size(), 1);

      // randomized transfers, spurious starts and aborts
      for (int i = 0; i < 40; i++) begin
         wait_idle();
         cycles($urandom_range(0, 3));
         launch(DW'($urandom), 1'($urandom), DW'($urandom), t0);
         if ($urandom_range(0, 5) == 0) begin
            cycles($urandom_range(1, 285));
            reset = 1'b1;
            next_cycle();
            reset = 1'b0;
         end else begin
            cycles($urandom_range(5, 200));
            start = 1'b1; tx_data = DW'($urandom);
            next_cycle();
            start = 1'b0;
         end
      end
      wait_idle();
      cycles(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
